interrupt_controller: RTL and testbench

- Interrupt source that drives the `interrupt`/`int_mux` inputs of the instruction decoder.
- Consumes the decoder's wfi indication (`pc_save`) and its rfi indication (`pc_mux == PC_SAVE` with `pc_save` low).
- Latches edge-triggered requests, prioritises them, redirects the PC to a per-source vector and holds the return PC.
- Sits between the external irq pins and the core datapath; no nesting.

---
 rtl/interrupt_controller.sv | 139 +++++++++++++
 tb/tb_interrupt_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches rising edges on irq pins, masks them with an
// enable register, picks the lowest-index request, redirects the PC to a
// per-source vector for one cycle and holds the return PC until the handler
// executes rfi. No nesting: new requests wait in pending while a handler runs.
//
// Ports:
//   clk, rst_n      core clock, synchronous active-low reset
//   irq_in          raw active-high requests (rising edge = request)
//   irq_en_we/wdata enable register write port
//   wfi_exec        one-cycle pulse when wfi executes
//   rfi_exec        one-cycle pulse when rfi executes
//   pc_next         address of the next sequential instruction
//   interrupt       one-cycle entry pulse to the decoder
//   int_mux         PC mux select for int_vector (same cycle as interrupt)
//   int_vector      handler entry address
//   saved_pc        return address for rfi
//   irq_active      handler in progress
//   irq_id          index of the source being serviced
//   halt            core stall while sleeping after wfi
//   irq_pending     pending register for status reads
module interrupt_controller #(
   parameter int unsigned           NUM_IRQ       = 4,
   parameter int unsigned           PC_WIDTH      = 16,
   parameter logic [PC_WIDTH-1:0]   VECTOR_BASE   = 16'h0010,
   parameter logic [PC_WIDTH-1:0]   VECTOR_STRIDE = 16'h0004
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_IRQ-1:0]  irq_in,
   input  logic                irq_en_we,
   input  logic [NUM_IRQ-1:0]  irq_en_wdata,
   input  logic                wfi_exec,
   input  logic                rfi_exec,
   input  logic [PC_WIDTH-1:0] pc_next,
   output logic                interrupt,
   output logic                int_mux,
   output logic [PC_WIDTH-1:0] int_vector,
   output logic [PC_WIDTH-1:0] saved_pc,
   output logic                irq_active,
   output logic [2:0]          irq_id,
   output logic                halt,
   output logic [NUM_IRQ-1:0]  irq_pending
);

   typedef enum logic [1:0] {StRun, StSleep, StEnter, StHandler} state_e;

   state_e              state_q, state_d;
   logic [NUM_IRQ-1:0]  prev_q, pending_q, pending_d, enable_q, req, clr;
   logic [PC_WIDTH-1:0] vector_q, saved_pc_q, win_vec;
   logic [2:0]          sel_q, irq_id_q, win_id;
   logic                win_valid;
   logic                interrupt_q, halt_q, active_q;

   assign req = pending_q & enable_q;

   // Lowest set index wins: scan downward so the last hit is the lowest.
   always_comb begin
      win_valid = 1'b0;
      win_id    = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_valid = 1'b1;
            win_id    = 3'(i);
         end
      end
   end

   assign win_vec = VECTOR_BASE + PC_WIDTH'(win_id) * VECTOR_STRIDE;

   // A new edge in the same cycle as the ENTER clear keeps the bit set.
   always_comb begin
      clr = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         clr[i] = (state_q == StEnter) && (sel_q == 3'(i));
      end
      pending_d = (pending_q & ~clr) | (irq_in & ~prev_q);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun: begin
            if (win_valid)     state_d = StEnter;
            else if (wfi_exec) state_d = StSleep;
         end
         StSleep: begin
            if (win_valid) state_d = StEnter;
         end
         StEnter:   state_d = StHandler;
         StHandler: begin
            if (rfi_exec) state_d = StRun;
         end
         default:   state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StRun;
         prev_q      <= '0;
         pending_q   <= '0;
         enable_q    <= '0;
         vector_q    <= '0;
         saved_pc_q  <= '0;
         sel_q       <= '0;
         irq_id_q    <= '0;
         interrupt_q <= 1'b0;
         halt_q      <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_q    <= irq_in;
         pending_q <= pending_d;
         if (irq_en_we) enable_q <= irq_en_wdata;
         // Winner is frozen on the way into ENTER so vector, clear and id agree.
         if (state_d == StEnter) begin
            sel_q    <= win_id;
            vector_q <= win_vec;
         end
         if (state_q == StEnter) begin
            saved_pc_q <= pc_next;
            irq_id_q   <= sel_q;
         end
         interrupt_q <= (state_d == StEnter);
         halt_q      <= (state_d == StSleep);
         active_q    <= (state_d == StHandler);
      end
   end

   assign interrupt   = interrupt_q;
   assign int_mux     = interrupt_q;
   assign halt        = halt_q;
   assign irq_active  = active_q;
   assign int_vector  = vector_q;
   assign saved_pc    = saved_pc_q;
   assign irq_id      = irq_id_q;
   assign irq_pending = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  irq_in;
   logic        irq_en_we;
   logic [3:0]  irq_en_wdata;
   logic        wfi_exec;
   logic        rfi_exec;
   logic [15:0] pc_next;
   logic        interrupt, int_mux, irq_active, halt;
   logic [15:0] int_vector, saved_pc;
   logic [2:0]  irq_id;
   logic [3:0]  irq_pending;

   int n_checks = 0;
   int n_errors = 0;

   interrupt_controller dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .irq_in       (irq_in),
      .irq_en_we    (irq_en_we),
      .irq_en_wdata (irq_en_wdata),
      .wfi_exec     (wfi_exec),
      .rfi_exec     (rfi_exec),
      .pc_next      (pc_next),
      .interrupt    (interrupt),
      .int_mux      (int_mux),
      .int_vector   (int_vector),
      .saved_pc     (saved_pc),
      .irq_active   (irq_active),
      .irq_id       (irq_id),
      .halt         (halt),
      .irq_pending  (irq_pending)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // Reference model: modes 0=run 1=sleep 2=enter 3=handler.
   int          m_mode;
   logic [3:0]  m_pend, m_en, m_prev;
   int          m_cur;
   logic [15:0] m_vec, m_saved;
   logic [2:0]  m_id;

   function automatic int lowest(input logic [3:0] v);
      int r = -1;
      for (int i = 3; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction

   task automatic model_clock();
      logic [3:0] req, np;
      int         w;
      if (!rst_n) begin
         m_mode = 0; m_pend = 0; m_en = 0; m_prev = 0; m_cur = 0;
         m_vec = 0; m_saved = 0; m_id = 0;
         return;
      end
      req = m_pend & m_en;
      w   = lowest(req);
      np  = m_pend;
      if (m_mode == 2) np[m_cur] = 1'b0;
      np = np | (irq_in & ~m_prev);
      case (m_mode)
         0, 1: begin
            if (w >= 0) begin
               m_mode = 2;
               m_cur  = w;
               m_vec  = 16'(16'h0010 + w * 4);
            end else if (m_mode == 0 && wfi_exec) begin
               m_mode = 1;
            end
         end
         2: begin
            m_saved = pc_next;
            m_id    = 3'(m_cur);
            m_mode  = 3;
         end
         default: if (rfi_exec) m_mode = 0;
      endcase
      if (irq_en_we) m_en = irq_en_wdata;
      m_prev = irq_in;
      m_pend = np;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      check("model interrupt", 32'(interrupt), 32'(m_mode == 2));
      check("model int_mux", 32'(int_mux), 32'(m_mode == 2));
      check("model halt", 32'(halt), 32'(m_mode == 1));
      check("model irq_active", 32'(irq_active), 32'(m_mode == 3));
      check("model int_vector", 32'(int_vector), 32'(m_vec));
      check("model saved_pc", 32'(saved_pc), 32'(m_saved));
      check("model irq_id", 32'(irq_id), 32'(m_id));
      check("model irq_pending", 32'(irq_pending), 32'(m_pend));
   endtask

   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
      compare_model();
   endtask

   task automatic drive(input logic [3:0] irq, input logic we, input logic [3:0] wd,
                        input logic wfi, input logic rfi);
      irq_in = irq; irq_en_we = we; irq_en_wdata = wd; wfi_exec = wfi; rfi_exec = rfi;
   endtask

   typedef struct {
      logic [3:0]  irq;
      logic        we;
      logic [3:0]  wdata;
      logic        wfi;
      logic        rfi;
      logic [15:0] pc;
      logic        e_int;
      logic        e_act;
      logic        e_halt;
      logic [3:0]  e_pend;
      logic [2:0]  e_id;
      logic [15:0] e_vec;
      logic [15:0] e_saved;
   } vec_t;

   vec_t tbl[15];
   int   cnt;

   initial begin
      //          irq  we wd   wfi rfi pc        int act hlt pend id vec       saved
      tbl[0]  = '{4'h0, 1, 4'hF, 0, 0, 16'h1234, 0, 0, 0, 4'h0, 0, 16'h0000, 16'h0000};
      tbl[1]  = '{4'h4, 0, 4'h0, 0, 0, 16'h1234, 0, 0, 0, 4'h4, 0, 16'h0000, 16'h0000};
      tbl[2]  = '{4'h0, 0, 4'h0, 0, 0, 16'h1234, 1, 0, 0, 4'h4, 0, 16'h0018, 16'h0000};
      tbl[3]  = '{4'h0, 0, 4'h0, 0, 0, 16'h1234, 0, 1, 0, 4'h0, 2, 16'h0018, 16'h1234};
      tbl[4]  = '{4'h0, 0, 4'h0, 0, 0, 16'h1234, 0, 1, 0, 4'h0, 2, 16'h0018, 16'h1234};
      tbl[5]  = '{4'h9, 0, 4'h0, 0, 0, 16'h1234, 0, 1, 0, 4'h9, 2, 16'h0018, 16'h1234};
      tbl[6]  = '{4'h0, 0, 4'h0, 0, 1, 16'h1234, 0, 0, 0, 4'h9, 2, 16'h0018, 16'h1234};
      tbl[7]  = '{4'h0, 0, 4'h0, 0, 0, 16'h1234, 1, 0, 0, 4'h9, 2, 16'h0010, 16'h1234};
      tbl[8]  = '{4'h0, 0, 4'h0, 0, 0, 16'h2000, 0, 1, 0, 4'h8, 0, 16'h0010, 16'h2000};
      tbl[9]  = '{4'h0, 0, 4'h0, 0, 1, 16'h2000, 0, 0, 0, 4'h8, 0, 16'h0010, 16'h2000};
      tbl[10] = '{4'h0, 0, 4'h0, 0, 0, 16'h2000, 1, 0, 0, 4'h8, 0, 16'h001C, 16'h2000};
      tbl[11] = '{4'h0, 0, 4'h0, 0, 0, 16'h2000, 0, 1, 0, 4'h0, 3, 16'h001C, 16'h2000};
      tbl[12] = '{4'h0, 0, 4'h0, 1, 0, 16'h2000, 0, 1, 0, 4'h0, 3, 16'h001C, 16'h2000};
      tbl[13] = '{4'h0, 0, 4'h0, 0, 1, 16'h2000, 0, 0, 0, 4'h0, 3, 16'h001C, 16'h2000};
      tbl[14] = '{4'h0, 0, 4'h0, 0, 1, 16'h2000, 0, 0, 0, 4'h0, 3, 16'h001C, 16'h2000};

      rst_n = 1'b0; pc_next = 16'h0;
      drive(4'h0, 0, 4'h0, 0, 0);
      step(); step();
      check("reset interrupt", 32'(interrupt), 0);
      check("reset irq_pending", 32'(irq_pending), 0);
      rst_n = 1'b1;

      // Directed table: entry, priority, back-to-back, stray wfi/rfi.
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].irq, tbl[i].we, tbl[i].wdata, tbl[i].wfi, tbl[i].rfi);
         pc_next = tbl[i].pc;
         step();
         check($sformatf("tbl[%0d] interrupt", i), 32'(interrupt), 32'(tbl[i].e_int));
         check($sformatf("tbl[%0d] int_mux", i), 32'(int_mux), 32'(tbl[i].e_int));
         check($sformatf("tbl[%0d] irq_active", i), 32'(irq_active), 32'(tbl[i].e_act));
         check($sformatf("tbl[%0d] halt", i), 32'(halt), 32'(tbl[i].e_halt));
         check($sformatf("tbl[%0d] pending", i), 32'(irq_pending), 32'(tbl[i].e_pend));
         check($sformatf("tbl[%0d] irq_id", i), 32'(irq_id), 32'(tbl[i].e_id));
         check($sformatf("tbl[%0d] int_vector", i), 32'(int_vector), 32'(tbl[i].e_vec));
         check($sformatf("tbl[%0d] saved_pc", i), 32'(saved_pc), 32'(tbl[i].e_saved));
      end

      // Sleep with everything disabled; wake once source 1 is enabled.
      drive(4'h0, 1, 4'h0, 0, 0); step();
      drive(4'h0, 0, 4'h0, 1, 0); step();
      check("sleep halt", 32'(halt), 1);
      drive(4'h0, 0, 4'h0, 0, 0);
      repeat (5) step();
      check("sleep halt held", 32'(halt), 1);
      drive(4'h2, 0, 4'h0, 0, 0); step();
      drive(4'h0, 0, 4'h0, 0, 1); step();
      check("sleep pending disabled", 32'(irq_pending), 32'h2);
      check("sleep halt with masked pending", 32'(halt), 1);
      drive(4'h0, 1, 4'h2, 0, 0); step();
      check("sleep halt at enable write", 32'(halt), 1);
      drive(4'h0, 0, 4'h0, 0, 0); step();
      check("wake interrupt", 32'(interrupt), 1);
      check("wake halt", 32'(halt), 0);
      check("wake vector", 32'(int_vector), 32'h0014);
      step();
      drive(4'h0, 0, 4'h0, 0, 1); step();
      drive(4'h0, 0, 4'h0, 0, 0); step();

      // Level held high: single entry; stray wfi in handler.
      drive(4'h0, 1, 4'hF, 0, 0); step();
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         drive(4'h1, 0, 4'h0, (k == 5), (k == 8));
         step();
         if (interrupt) cnt++;
      end
      drive(4'h0, 0, 4'h0, 0, 0);
      repeat (3) begin step(); if (interrupt) cnt++; end
      check("held level entry count", 32'(cnt), 1);
      check("held level pending", 32'(irq_pending), 0);
      check("held level active after rfi", 32'(irq_active), 0);

      // Edge arrives in the same cycle ENTER clears that bit.
      drive(4'h2, 0, 4'h0, 0, 0); step();
      drive(4'h0, 0, 4'h0, 0, 0); step();
      check("clr race enter", 32'(interrupt), 1);
      drive(4'h2, 0, 4'h0, 0, 0); step();
      check("clr race pending kept", 32'(irq_pending), 32'h2);
      drive(4'h0, 0, 4'h0, 0, 1); step();
      drive(4'h0, 0, 4'h0, 0, 0); step();
      check("clr race retaken", 32'(interrupt), 1);
      check("clr race vector", 32'(int_vector), 32'h0014);
      step();
      check("clr race pending cleared", 32'(irq_pending), 0);
      drive(4'h0, 0, 4'h0, 0, 1); step();

      // Reset in the middle of a handler with requests pending.
      drive(4'h1, 0, 4'h0, 0, 0); step();
      drive(4'h0, 0, 4'h0, 0, 0); step(); step(); step();
      drive(4'h6, 0, 4'h0, 0, 0); step();
      drive(4'h0, 0, 4'h0, 0, 0); step();
      check("pre-reset pending", 32'(irq_pending), 32'h6);
      check("pre-reset active", 32'(irq_active), 1);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      check("mid reset outputs",
            {irq_active, halt, interrupt, int_mux, irq_id, irq_pending, 12'h0, int_vector},
            32'h0);
      check("mid reset saved_pc", 32'(saved_pc), 0);
      cnt = 0;
      drive(4'h2, 0, 4'h0, 0, 0); step();
      drive(4'h0, 0, 4'h0, 0, 0);
      repeat (5) begin step(); if (interrupt) cnt++; end
      check("post reset disabled no entry", 32'(cnt), 0);
      drive(4'h0, 1, 4'hF, 0, 0); step();
      drive(4'h0, 0, 4'h0, 0, 0); step();
      check("post reset re-enabled entry", 32'(interrupt), 1);
      step();
      drive(4'h0, 0, 4'h0, 0, 1); step();

      // Randomized traffic against the model.
      for (int k = 0; k < 1500; k++) begin
         irq_in       = irq_in ^ (($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
         irq_en_we    = ($urandom_range(0, 15) == 0);
         irq_en_wdata = 4'($urandom_range(0, 15));
         wfi_exec     = ($urandom_range(0, 9) == 0);
         rfi_exec     = ($urandom_range(0, 5) == 0);
         pc_next      = 16'($urandom);
         rst_n        = ($urandom_range(0, 299) != 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
